// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: enable polarities,
// address widths and the controller state encoding.
package pipe_ctrl_pkg;

    localparam logic HOLD_ENABLE  = 1'b1;
    localparam logic HOLD_DISABLE = 1'b0;
    localparam logic JUMP_ENABLE  = 1'b1;
    localparam logic JUMP_DISABLE = 1'b0;
    localparam logic RST_ENABLE   = 1'b0;

    localparam int INST_ADDR_W  = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int STALL_CNT_W  = 32;
    localparam int FLUSH_CNT_W  = 16;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [REG_ADDR_W-1:0]  reg_addr_t;

    localparam inst_addr_t ZERO_WORD = '0;
    localparam reg_addr_t  REG_ZERO  = '0;

    typedef enum logic {
        STATE_RUN       = 1'b0,
        STATE_JUMP_PEND = 1'b1
    } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// controller (slave).
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    reg_addr_t  id_rs1_addr_i;
    reg_addr_t  id_rs2_addr_i;
    logic       id_rs1_used_i;
    logic       id_rs2_used_i;
    reg_addr_t  ex_reg_w_addr_i;
    logic       ex_mem_r_ena_i;
    logic       ex_jump_ena_i;
    inst_addr_t ex_jump_addr_i;
    logic       ex_busy_i;
    logic       ifu_wait_i;
    logic       cnt_clr_i;

    logic                   hold_pc_o;
    logic                   hold_if_id_o;
    logic                   hold_id_ex_o;
    logic                   flush_if_id_o;
    logic                   flush_id_ex_o;
    logic                   flush_ex_mem_o;
    logic                   pc_jump_ena_o;
    inst_addr_t             pc_jump_addr_o;
    logic [STALL_CNT_W-1:0] stall_cnt_o;
    logic [FLUSH_CNT_W-1:0] flush_cnt_o;

    modport master (
        output id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
               ex_reg_w_addr_i, ex_mem_r_ena_i, ex_jump_ena_i, ex_jump_addr_i,
               ex_busy_i, ifu_wait_i, cnt_clr_i,
        input  hold_pc_o, hold_if_id_o, hold_id_ex_o,
               flush_if_id_o, flush_id_ex_o, flush_ex_mem_o,
               pc_jump_ena_o, pc_jump_addr_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
               ex_reg_w_addr_i, ex_mem_r_ena_i, ex_jump_ena_i, ex_jump_addr_i,
               ex_busy_i, ifu_wait_i, cnt_clr_i,
        output hold_pc_o, hold_if_id_o, hold_id_ex_o,
               flush_if_id_o, flush_id_ex_o, flush_ex_mem_o,
               pc_jump_ena_o, pc_jump_addr_o, stall_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/pipe_ctrl_load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic      ex_mem_r_ena_i,
    input  reg_addr_t ex_reg_w_addr_i,
    input  reg_addr_t id_rs1_addr_i,
    input  logic      id_rs1_used_i,
    input  reg_addr_t id_rs2_addr_i,
    input  logic      id_rs2_used_i,
    output logic      load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_rs1_used_i && (id_rs1_addr_i == ex_reg_w_addr_i);
    assign rs2_hit = id_rs2_used_i && (id_rs2_addr_i == ex_reg_w_addr_i);

    // x0 is hard-wired to zero, so a load into it never creates a dependency.
    assign load_use_o = ex_mem_r_ena_i && (ex_reg_w_addr_i != REG_ZERO)
                        && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall/flush/redirect generation with a pending
// redirect state for a busy fetch bus, plus stall and flush statistics.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk_100MHz,
    input  logic        arst_n,
    pipe_ctrl_if.slave  bus
);

    state_t                 state;
    state_t                 state_nxt;
    inst_addr_t             pend_addr;
    inst_addr_t             pend_addr_nxt;
    logic                   load_use;
    logic                   jump_accept;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic [FLUSH_CNT_W-1:0] flush_cnt;

    logic       hold_pc;
    logic       hold_if_id;
    logic       hold_id_ex;
    logic       flush_if_id;
    logic       flush_id_ex;
    logic       flush_ex_mem;
    logic       jump_ena;
    inst_addr_t jump_addr;

    function automatic logic [STALL_CNT_W-1:0] sat_inc_stall(
        input logic [STALL_CNT_W-1:0] v
    );
        return (v == '1) ? v : v + STALL_CNT_W'(1);
    endfunction

    load_use_detect u_load_use_detect (
        .ex_mem_r_ena_i  (bus.ex_mem_r_ena_i),
        .ex_reg_w_addr_i (bus.ex_reg_w_addr_i),
        .id_rs1_addr_i   (bus.id_rs1_addr_i),
        .id_rs1_used_i   (bus.id_rs1_used_i),
        .id_rs2_addr_i   (bus.id_rs2_addr_i),
        .id_rs2_used_i   (bus.id_rs2_used_i),
        .load_use_o      (load_use)
    );

    // Hazard priority in RUN: busy > jump > load-use > fetch wait.
    always_comb begin
        hold_pc       = HOLD_DISABLE;
        hold_if_id    = HOLD_DISABLE;
        hold_id_ex    = HOLD_DISABLE;
        flush_if_id   = JUMP_DISABLE;
        flush_id_ex   = JUMP_DISABLE;
        flush_ex_mem  = JUMP_DISABLE;
        jump_ena      = JUMP_DISABLE;
        jump_addr     = ZERO_WORD;
        jump_accept   = 1'b0;
        state_nxt     = state;
        pend_addr_nxt = pend_addr;

        case (state)
            STATE_RUN: begin
                if (bus.ex_busy_i) begin
                    hold_pc      = HOLD_ENABLE;
                    hold_if_id   = HOLD_ENABLE;
                    hold_id_ex   = HOLD_ENABLE;
                    flush_ex_mem = JUMP_ENABLE;
                end else if (bus.ex_jump_ena_i) begin
                    flush_if_id = JUMP_ENABLE;
                    flush_id_ex = JUMP_ENABLE;
                    jump_accept = 1'b1;
                    if (bus.ifu_wait_i) begin
                        pend_addr_nxt = bus.ex_jump_addr_i;
                        state_nxt     = STATE_JUMP_PEND;
                    end else begin
                        jump_ena  = JUMP_ENABLE;
                        jump_addr = bus.ex_jump_addr_i;
                    end
                end else if (load_use) begin
                    // Bubble into EX while the load completes; ID keeps its instruction.
                    hold_pc     = HOLD_ENABLE;
                    hold_if_id  = HOLD_ENABLE;
                    flush_id_ex = JUMP_ENABLE;
                end else if (bus.ifu_wait_i) begin
                    hold_pc     = HOLD_ENABLE;
                    flush_if_id = JUMP_ENABLE;
                end
            end
            STATE_JUMP_PEND: begin
                // Keep presenting the redirect until the fetch bus takes it.
                jump_ena    = JUMP_ENABLE;
                jump_addr   = pend_addr;
                flush_if_id = JUMP_ENABLE;
                flush_id_ex = JUMP_ENABLE;
                if (!bus.ifu_wait_i) begin
                    state_nxt = STATE_RUN;
                end
            end
            default: begin
                state_nxt = STATE_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (arst_n == RST_ENABLE) begin
            state     <= STATE_RUN;
            pend_addr <= ZERO_WORD;
        end else begin
            state     <= state_nxt;
            pend_addr <= pend_addr_nxt;
        end
    end

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (arst_n == RST_ENABLE) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (bus.cnt_clr_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hold_pc == HOLD_ENABLE) begin
                stall_cnt <= sat_inc_stall(stall_cnt);
            end
            if (jump_accept) begin
                flush_cnt <= flush_cnt + FLUSH_CNT_W'(1);
            end
        end
    end

    assign bus.hold_pc_o      = hold_pc;
    assign bus.hold_if_id_o   = hold_if_id;
    assign bus.hold_id_ex_o   = hold_id_ex;
    assign bus.flush_if_id_o  = flush_if_id;
    assign bus.flush_id_ex_o  = flush_id_ex;
    assign bus.flush_ex_mem_o = flush_ex_mem;
    assign bus.pc_jump_ena_o  = jump_ena;
    assign bus.pc_jump_addr_o = jump_addr;
    assign bus.stall_cnt_o    = stall_cnt;
    assign bus.flush_cnt_o    = flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a table of single-cycle hazard vectors plus
// hand-written sequences for load-use, pending jumps, busy stalls and reset.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    // Flag order: {hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, flush_ex_mem, pc_jump_ena}
    localparam logic [6:0] F_IDLE  = 7'b000_000_0;
    localparam logic [6:0] F_BUSY  = 7'b111_001_0;
    localparam logic [6:0] F_LU    = 7'b110_010_0;
    localparam logic [6:0] F_WAIT  = 7'b100_100_0;
    localparam logic [6:0] F_JUMP  = 7'b000_110_1;
    localparam logic [6:0] F_JENT  = 7'b000_110_0;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [4:0]  rd;
        logic        mr;
        logic        jmp;
        logic [31:0] ja;
        logic        busy;
        logic        wt;
        logic [6:0]  ef;
        logic [31:0] ea;
    } vec_t;

    logic clk_100MHz;
    logic arst_n;
    pipe_ctrl_if bus();

    pipe_ctrl dut (
        .clk_100MHz (clk_100MHz),
        .arst_n     (arst_n),
        .bus        (bus)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic mr, input logic jmp, input logic [31:0] ja,
                                input logic busy, input logic wt,
                                input logic [6:0] ef, input logic [31:0] ea);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd; v.mr = mr;
        v.jmp = jmp; v.ja = ja; v.busy = busy; v.wt = wt; v.ef = ef; v.ea = ea;
        return v;
    endfunction

    function automatic logic [31:0] flags();
        return {25'd0, bus.hold_pc_o, bus.hold_if_id_o, bus.hold_id_ex_o,
                bus.flush_if_id_o, bus.flush_id_ex_o, bus.flush_ex_mem_o, bus.pc_jump_ena_o};
    endfunction

    task automatic apply(input vec_t v);
        bus.id_rs1_addr_i   = v.rs1;
        bus.id_rs2_addr_i   = v.rs2;
        bus.id_rs1_used_i   = v.u1;
        bus.id_rs2_used_i   = v.u2;
        bus.ex_reg_w_addr_i = v.rd;
        bus.ex_mem_r_ena_i  = v.mr;
        bus.ex_jump_ena_i   = v.jmp;
        bus.ex_jump_addr_i  = v.ja;
        bus.ex_busy_i       = v.busy;
        bus.ifu_wait_i      = v.wt;
    endtask

    task automatic idle();
        apply('0);
        bus.cnt_clr_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_100MHz);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] s0;
        logic [31:0] f0;
        int          ena_cycles;
        int          exp_stall;
        int          exp_flush;

        //           rs1 rs2 u1 u2 rd mr jmp ja           busy wt flags   addr
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,       0, 0, F_IDLE, 32'h0);
        vecs[1]  = mk(3, 0, 1, 0, 3, 1, 0, 32'h0,       0, 0, F_LU,   32'h0);
        vecs[2]  = mk(0, 7, 0, 1, 7, 1, 0, 32'h0,       0, 0, F_LU,   32'h0);
        vecs[3]  = mk(1, 7, 1, 0, 7, 1, 0, 32'h0,       0, 0, F_IDLE, 32'h0);
        vecs[4]  = mk(0, 0, 1, 0, 0, 1, 0, 32'h0,       0, 0, F_IDLE, 32'h0);
        vecs[5]  = mk(3, 0, 1, 0, 3, 0, 0, 32'h0,       0, 0, F_IDLE, 32'h0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,       0, 1, F_WAIT, 32'h0);
        vecs[7]  = mk(9, 0, 1, 0, 9, 1, 0, 32'h0,       0, 1, F_LU,   32'h0);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 1, 32'h40,      0, 0, F_JUMP, 32'h40);
        vecs[9]  = mk(4, 0, 1, 0, 4, 1, 1, 32'h80,      0, 0, F_JUMP, 32'h80);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,       1, 0, F_BUSY, 32'h0);
        vecs[11] = mk(4, 0, 1, 0, 4, 1, 1, 32'h99,      1, 1, F_BUSY, 32'h0);

        // Reset state, all inputs low
        arst_n = 1'b0;
        idle();
        #12;
        chk("reset_flags", flags(), 32'h0);
        chk("reset_addr",  bus.pc_jump_addr_o, 32'h0);
        chk("reset_stall", bus.stall_cnt_o, 32'h0);
        chk("reset_flush", {16'd0, bus.flush_cnt_o}, 32'h0);
        @(negedge clk_100MHz);
        arst_n = 1'b1;
        step();

        // Single-cycle vectors, all of which leave the controller in RUN
        exp_stall = 0;
        exp_flush = 0;
        foreach (vecs[i]) begin
            apply(vecs[i]);
            @(negedge clk_100MHz);
            chk($sformatf("vec%0d_flags", i), flags(), {25'd0, vecs[i].ef});
            chk($sformatf("vec%0d_addr", i), bus.pc_jump_addr_o, vecs[i].ea);
            if (vecs[i].ef[6]) exp_stall++;
            if (vecs[i].ef[0]) exp_flush++;
            step();
        end
        idle();
        @(negedge clk_100MHz);
        chk("table_stall_cnt", bus.stall_cnt_o, 32'(exp_stall));
        chk("table_flush_cnt", {16'd0, bus.flush_cnt_o}, 32'(exp_flush));
        step();

        // Load to x5 feeding rs2 of ID: exactly one bubble cycle
        s0 = bus.stall_cnt_o;
        bus.ex_mem_r_ena_i = 1'b1; bus.ex_reg_w_addr_i = 5'd5;
        bus.id_rs2_addr_i = 5'd5;  bus.id_rs2_used_i = 1'b1;
        @(negedge clk_100MHz);
        chk("lu_x5_flags", flags(), {25'd0, F_LU});
        step();
        idle();
        bus.id_rs2_addr_i = 5'd5; bus.id_rs2_used_i = 1'b1;
        @(negedge clk_100MHz);
        chk("lu_x5_after", flags(), 32'h0);
        chk("lu_x5_stall", bus.stall_cnt_o, s0 + 32'd1);
        step();
        idle();

        // Load to x0 matching rs1=x0: no stall
        s0 = bus.stall_cnt_o;
        bus.ex_mem_r_ena_i = 1'b1; bus.id_rs1_used_i = 1'b1;
        @(negedge clk_100MHz);
        chk("lu_x0_flags", flags(), 32'h0);
        step();
        idle();
        @(negedge clk_100MHz);
        chk("lu_x0_stall", bus.stall_cnt_o, s0);
        step();

        // Jump to 0x100 with fetch ready: same-cycle redirect
        f0 = {16'd0, bus.flush_cnt_o};
        bus.ex_jump_ena_i = 1'b1; bus.ex_jump_addr_i = 32'h100;
        @(negedge clk_100MHz);
        chk("jmp100_flags", flags(), {25'd0, F_JUMP});
        chk("jmp100_addr", bus.pc_jump_addr_o, 32'h100);
        step();
        idle();
        @(negedge clk_100MHz);
        chk("jmp100_back_run", flags(), 32'h0);
        chk("jmp100_flush_cnt", {16'd0, bus.flush_cnt_o}, f0 + 32'd1);
        step();

        // Jump to 0x200 while fetch is stalled; fetch wait persists for three
        // JUMP_PEND cycles, busy/jump inputs meanwhile must be ignored.
        f0 = {16'd0, bus.flush_cnt_o};
        s0 = bus.stall_cnt_o;
        bus.ex_jump_ena_i = 1'b1; bus.ex_jump_addr_i = 32'h200; bus.ifu_wait_i = 1'b1;
        @(negedge clk_100MHz);
        chk("jmp200_entry_flags", flags(), {25'd0, F_JENT});
        chk("jmp200_entry_addr", bus.pc_jump_addr_o, 32'h0);
        step();
        bus.ex_jump_addr_i = 32'hBAD0; bus.ex_busy_i = 1'b1;
        ena_cycles = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) bus.ifu_wait_i = 1'b0;
            @(negedge clk_100MHz);
            chk($sformatf("jmp200_pend%0d_flags", k), flags(), {25'd0, F_JUMP});
            chk($sformatf("jmp200_pend%0d_addr", k), bus.pc_jump_addr_o, 32'h200);
            if (bus.pc_jump_ena_o) ena_cycles++;
            step();
        end
        idle();
        @(negedge clk_100MHz);
        if (bus.pc_jump_ena_o) ena_cycles++;
        chk("jmp200_ena_cycles", 32'(ena_cycles), 32'd4);
        chk("jmp200_back_run", flags(), 32'h0);
        chk("jmp200_flush_cnt", {16'd0, bus.flush_cnt_o}, f0 + 32'd1);
        chk("jmp200_stall_cnt", bus.stall_cnt_o, s0);
        step();

        // Busy for five cycles with a jump and a load-use also present
        s0 = bus.stall_cnt_o;
        f0 = {16'd0, bus.flush_cnt_o};
        bus.ex_busy_i = 1'b1; bus.ex_jump_ena_i = 1'b1; bus.ex_jump_addr_i = 32'h300;
        bus.ex_mem_r_ena_i = 1'b1; bus.ex_reg_w_addr_i = 5'd4;
        bus.id_rs1_addr_i = 5'd4; bus.id_rs1_used_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_100MHz);
            chk($sformatf("busy%0d_flags", k), flags(), {25'd0, F_BUSY});
            chk($sformatf("busy%0d_addr", k), bus.pc_jump_addr_o, 32'h0);
            step();
        end
        idle();
        @(negedge clk_100MHz);
        chk("busy_stall_cnt", bus.stall_cnt_o, s0 + 32'd5);
        chk("busy_flush_cnt", {16'd0, bus.flush_cnt_o}, f0);
        step();

        // Reset pulse while a redirect is pending
        bus.ex_jump_ena_i = 1'b1; bus.ex_jump_addr_i = 32'h400; bus.ifu_wait_i = 1'b1;
        step();
        bus.ex_jump_ena_i = 1'b0;
        @(negedge clk_100MHz);
        chk("rst_pend_ena", 32'(bus.pc_jump_ena_o), 32'd1);
        #1 arst_n = 1'b0;
        #1;
        chk("rst_pend_flags", flags(), {25'd0, F_WAIT});
        chk("rst_pend_addr", bus.pc_jump_addr_o, 32'h0);
        chk("rst_pend_stall", bus.stall_cnt_o, 32'h0);
        chk("rst_pend_flush", {16'd0, bus.flush_cnt_o}, 32'h0);
        idle();
        @(negedge clk_100MHz);
        arst_n = 1'b1;
        step();
        chk("rst_released_flags", flags(), 32'h0);

        // Make both counters non-zero, then clear while hold_pc is asserted
        bus.ifu_wait_i = 1'b1;
        step();
        idle();
        bus.ex_jump_ena_i = 1'b1; bus.ex_jump_addr_i = 32'h10;
        step();
        idle();
        @(negedge clk_100MHz);
        chk("pre_clr_stall", bus.stall_cnt_o, 32'd1);
        chk("pre_clr_flush", {16'd0, bus.flush_cnt_o}, 32'd1);
        step();
        bus.ifu_wait_i = 1'b1; bus.cnt_clr_i = 1'b1;
        @(negedge clk_100MHz);
        chk("clr_flags", flags(), {25'd0, F_WAIT});
        step();
        idle();
        @(negedge clk_100MHz);
        chk("clr_stall", bus.stall_cnt_o, 32'h0);
        chk("clr_flush", {16'd0, bus.flush_cnt_o}, 32'h0);
        chk("clr_idle_flags", flags(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk_100MHz, input, 1 bit: system clock; all state updates on its rising edge.
REQ-002 SHALL have port arst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have inputs id_rs1_addr_i and id_rs2_addr_i, 5 bits each: source registers of the instruction in ID.
REQ-004 SHALL have inputs id_rs1_used_i and id_rs2_used_i, 1 bit each: the ID instruction reads rs1 / rs2.
REQ-005 SHALL have inputs ex_reg_w_addr_i (5 bits) and ex_mem_r_ena_i (1 bit): destination register and load flag of the instruction in EX.
REQ-006 SHALL have inputs ex_jump_ena_i (1 bit) and ex_jump_addr_i (32 bits): taken jump or branch resolved in EX, and its target.
REQ-007 SHALL have input ex_busy_i, 1 bit: a multi-cycle EX operation (mul/div) is not yet complete.
REQ-008 SHALL have input ifu_wait_i, 1 bit: the instruction-fetch bus is stalled and cannot accept a new PC.
REQ-009 SHALL have input cnt_clr_i, 1 bit: synchronous clear of both statistics counters.
REQ-010 SHALL have outputs hold_pc_o, hold_if_id_o and hold_id_ex_o, 1 bit each, in `HOLD_ENABLE polarity.
REQ-011 SHALL have outputs flush_if_id_o, flush_id_ex_o and flush_ex_mem_o, 1 bit each, in `JUMP_ENABLE polarity.
REQ-012 SHALL have outputs pc_jump_ena_o (1 bit) and pc_jump_addr_o (32 bits): PC redirect request and target.
REQ-013 SHALL have outputs stall_cnt_o (32 bits) and flush_cnt_o (16 bits): statistics counters.

Function
REQ-014 SHALL implement an FSM with states RUN and JUMP_PEND, plus a 32-bit pending-target register.
REQ-015 SHALL drive all hold, flush and jump outputs combinationally from the current state and inputs, with zero-cycle latency.
REQ-016 SHALL apply, in RUN, exactly one priority branch per cycle, in this order: busy > jump > load-use > ifu_wait.
REQ-017 Busy (RUN, ex_busy_i=1) SHALL assert hold_pc, hold_if_id, hold_id_ex and flush_ex_mem, ignore ex_jump_ena_i, and remain in RUN.
REQ-018 Jump (RUN, ex_jump_ena_i=1, ex_busy_i=0) SHALL assert flush_if_id and flush_id_ex.
REQ-019 On a jump with ifu_wait_i=0, SHALL assert pc_jump_ena_o with pc_jump_addr_o=ex_jump_addr_i in the same cycle.
REQ-020 On a jump with ifu_wait_i=1, SHALL latch ex_jump_addr_i into the pending-target register and go to JUMP_PEND.
REQ-021 In JUMP_PEND, SHALL assert pc_jump_ena_o, pc_jump_addr_o=pending target, flush_if_id and flush_id_ex every cycle.
REQ-022 SHALL leave JUMP_PEND for RUN after the first cycle in which ifu_wait_i=0, and SHALL ignore ex_busy_i and ex_jump_ena_i while in JUMP_PEND.
REQ-023 Load-use SHALL be detected when ex_mem_r_ena_i=1, ex_reg_w_addr_i!=0, and the address matches id_rs1_addr_i with id_rs1_used_i=1, or id_rs2_addr_i with id_rs2_used_i=1.
REQ-024 On load-use, SHALL assert hold_pc, hold_if_id and flush_id_ex (bubble) and SHALL NOT assert hold_id_ex.
REQ-025 On ifu_wait_i=1 with no higher-priority condition, SHALL assert hold_pc and flush_if_id.
REQ-026 SHALL never assert hold and flush for the same stage in the same cycle, because downstream registers give hold priority over flush.
REQ-027 SHALL drive pc_jump_addr_o to `ZERO_WORD whenever pc_jump_ena_o=0.
REQ-028 stall_cnt_o SHALL increment by 1 in each cycle with hold_pc_o=1 and saturate at 0xFFFFFFFF.
REQ-029 flush_cnt_o SHALL increment once per accepted jump (the entry cycle only, not each JUMP_PEND cycle) and wrap at 0xFFFF.
REQ-030 cnt_clr_i SHALL zero both counters on the next edge and SHALL take priority over a simultaneous increment.

Reset
REQ-031 While arst_n=0, SHALL force state=RUN, pending target=`ZERO_WORD, and both counters=0, asynchronously.
REQ-032 Reset asserted in JUMP_PEND SHALL discard the pending jump; after reset, with all inputs 0, every output SHALL be 0.

Structure
REQ-033 SHALL take `HOLD_ENABLE, `JUMP_ENABLE, `ZERO_WORD, `INST_ADDR, `REG_ADDR and `RST_ENABLE from the shared define.v, and SHALL add `STATE_RUN and `STATE_JUMP_PEND there.
REQ-034 SHALL place the REQ-023 comparison in a combinational sub-module named load_use_detect.

Verification
REQ-035 The bench SHALL cover: load at EX with rd=x5 and ID rs2=x5 used -> exactly 1 cycle with hold_pc=hold_if_id=flush_id_ex=1 and hold_id_ex=0.
REQ-036 The bench SHALL cover: load with rd=x0 matching rs1=x0 -> no stall.
REQ-037 The bench SHALL cover: jump to 0x0000_0100 with ifu_wait_i=0 -> same-cycle pc_jump_ena_o=1, pc_jump_addr_o=0x100, and flush_cnt_o increments by 1.
REQ-038 The bench SHALL cover: jump to 0x0000_0200 with ifu_wait_i=1 for 3 cycles -> pc_jump_ena_o high for 4 cycles at 0x200, then RUN, with flush_cnt_o incremented by exactly 1.
REQ-039 The bench SHALL cover: ex_busy_i high for 5 cycles with ex_jump_ena_i=1 and load-use present -> 5 cycles of triple hold plus flush_ex_mem, no jump output, and stall_cnt_o advanced by 5.
REQ-040 The bench SHALL cover: arst_n pulsed low in JUMP_PEND, then cnt_clr_i with hold_pc=1 -> RUN, pc_jump_ena_o=0, and counters 0.
